// File: rtl/shift_seq.sv
// shift_seq: multi-cycle sequencer for register-specified shifts
// (ARM "Rm, <type> Rs", amount = Rs[7:0]). Applies the effective amount in
// steps of at most STEP_MAX bits per cycle through `shifter` and returns the
// A32 result plus shifter carry-out.
//
// Optional feature macro: SHIFT_SEQ_RRX_EN (adds the RRX path on req_rrx).
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (req_ready == state is IDLE)
//   req_data                 Rm
//   req_amount               Rs[7:0]
//   req_type                 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req_carry                CPSR.C at issue
//   req_rrx                  RRX request (only with SHIFT_SEQ_RRX_EN)
//   flush                    synchronous abort, back to IDLE next edge
//   res_valid/res_ready      result handshake
//   res_data, res_carry      shifted value and carry-out
//   busy                     state is RUN or DONE

// Combinational single-step barrel shifter. amt is assumed nonzero for ROR.
module shifter (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  input  logic [1:0]  typ,
  output logic [31:0] dout
);
  always_comb begin
    dout = din;
    case (typ)
      2'b00:   dout = din << amt;
      2'b01:   dout = din >> amt;
      2'b10:   dout = $unsigned($signed(din) >>> amt);
      default: dout = (din >> amt) | (din << (6'd32 - {1'b0, amt}));
    endcase
  end
endmodule

module shift_seq #(
  parameter int STEP_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [7:0]  req_amount,
  input  logic [1:0]  req_type,
  input  logic        req_carry,
  input  logic        req_rrx,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_carry,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;       // working register, doubles as result
  logic        carry_q, carry_d;
  logic        fcz_q, fcz_d;   // force carry-out to zero (LSL/LSR by >32)
  logic [5:0]  rem_q, rem_d;
  logic [1:0]  typ_q, typ_d;

  logic [5:0]  step;
  logic [31:0] sh_out;
  logic        step_carry;
  logic [5:0]  amt_sat;
  logic [5:0]  eff;

`ifdef SHIFT_SEQ_RRX_EN
  logic rrx_q, rrx_d;
`else
  logic unused_rrx;
  assign unused_rrx = req_rrx;
`endif

  assign step = (rem_q > 6'(STEP_MAX)) ? 6'(STEP_MAX) : rem_q;

  shifter u_shifter (
    .din  (w_q),
    .amt  (step[4:0]),
    .typ  (typ_q),
    .dout (sh_out)
  );

  // Carry is the last bit shifted out by this step.
  always_comb begin
    case (typ_q)
      2'b00:        step_carry = w_q[5'(6'd32 - step)];
      2'b01, 2'b10: step_carry = w_q[5'(step - 6'd1)];
      default:      step_carry = sh_out[31];
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    carry_d = carry_q;
    fcz_d   = fcz_q;
    rem_d   = rem_q;
    typ_d   = typ_q;
`ifdef SHIFT_SEQ_RRX_EN
    rrx_d   = rrx_q;
`endif
    amt_sat = (req_amount > 8'd32) ? 6'd32 : req_amount[5:0];
    eff     = (req_type == 2'b11) ? {1'b0, req_amount[4:0]} : amt_sat;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          w_d     = req_data;
          typ_d   = req_type;
          rem_d   = eff;
          fcz_d   = (req_type[1] == 1'b0) && (req_amount > 8'd32);
          // ROR by a nonzero multiple of 32 leaves Rm and reports Rm[31].
          carry_d = (req_type == 2'b11 && req_amount != 8'd0) ? req_data[31]
                                                              : req_carry;
          state_d = (eff == 6'd0) ? S_DONE : S_RUN;
`ifdef SHIFT_SEQ_RRX_EN
          rrx_d   = 1'b0;
          if (req_rrx && req_type == 2'b11) begin
            rrx_d   = 1'b1;
            fcz_d   = 1'b0;
            carry_d = req_carry;
            rem_d   = 6'd1;
            state_d = S_RUN;
          end
`endif
        end
      end
      S_RUN: begin
`ifdef SHIFT_SEQ_RRX_EN
        if (rrx_q) begin
          w_d     = {carry_q, w_q[31:1]};
          carry_d = w_q[0];
          rem_d   = 6'd0;
          state_d = S_DONE;
        end else
`endif
        begin
          w_d     = sh_out;
          carry_d = step_carry;
          rem_d   = rem_q - step;
          if (rem_q == step) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      carry_q <= 1'b0;
      fcz_q   <= 1'b0;
      rem_q   <= '0;
      typ_q   <= '0;
`ifdef SHIFT_SEQ_RRX_EN
      rrx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      carry_q <= carry_d;
      fcz_q   <= fcz_d;
      rem_q   <= rem_d;
      typ_q   <= typ_d;
`ifdef SHIFT_SEQ_RRX_EN
      rrx_q   <= rrx_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = w_q;
  assign res_carry = carry_q & ~fcz_q;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequencer for register-specified shifts (ARM "Rm, <type> Rs", shift amount = Rs[7:0]). It accepts one request per handshake and applies the effective amount in steps of at most 16 bits per cycle through the existing `shifter` module. It produces the ARM A32 result and shifter carry-out. It sits between decode/operand fetch and the ALU operand-2 mux, and stalls the issuing stage through `req_ready` while busy.

## Interface
- `STEP_MAX`, default 16: maximum bits shifted per RUN cycle; legal range 1..31.
- `clk` input, 1 bit: the only clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request.
- `req_data` input, 32 bits: Rm value.
- `req_amount` input, 8 bits: Rs[7:0].
- `req_type` input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `req_carry` input, 1 bit: current CPSR.C.
- `req_rrx` input, 1 bit: request RRX. Used only under `SHIFT_SEQ_RRX_EN`.
- `flush` input, 1 bit: synchronous abort.
- `res_valid` output, 1 bit: result available.
- `res_ready` input, 1 bit: consumer accepts the result.
- `res_data` output, 32 bits: shifted value.
- `res_carry` output, 1 bit: shifter carry-out.
- `busy` output, 1 bit: high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE
  - `req_ready` is 1.
  - On `req_valid && req_ready`, latch the data, type and carry, compute `eff` and the per-type rule below, then go to RUN. If `eff` is 0, go directly to DONE with `res_data` = Rm and `res_carry` = `req_carry`.
- Effective amount (`eff`) by type:
  - LSL/LSR: `eff` = min(amount, 32). If amount > 32, set the force-carry-zero flag.
  - ASR: `eff` = min(amount, 32).
  - ROR: `eff` = amount[4:0]. If amount ≠ 0 and amount[4:0] = 0, `eff` = 0, the result is Rm, and the carry is Rm[31].
- RUN
  - Each cycle: step = min(remaining, `STEP_MAX`), always nonzero. Drive `shifter` with the working register, step and type, then write its output back to the working register.
  - Per-step carry is the last bit shifted out: LSL → w[32−step]; LSR/ASR → w[step−1]; ROR → shifted result bit 31.
  - `remaining` decrements by step. When it reaches 0, go to DONE.
- DONE
  - `res_valid` is 1. `res_data` and `res_carry` stay stable until `res_ready`.
  - If the force-carry-zero flag is set, `res_carry` = 0.
  - When `res_valid && res_ready`, go to IDLE.
- `flush` in any state returns the FSM to IDLE on the next edge. The in-flight result is discarded and `res_valid` drops.
- `busy` is 1 whenever the state is not IDLE.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `res_valid` = 0, `res_data` = 0, `res_carry` = 0, `busy` = 0.
- Asserting `rst` mid-operation forces these values immediately, with no clock edge needed.
- Number of RUN steps = ceil(`eff` / `STEP_MAX`).
- `res_valid` rises steps + 1 edges after the accept edge. For `eff` = 0 this is the first edge after accept.
- `req_ready` is combinationally equal to (state == IDLE). It never depends on `req_valid`.
- A new request can be accepted no earlier than the edge after the result handshake. There is no accept in the same cycle as result retirement.
- If `flush` and `res_ready` arrive together in DONE, the block returns to IDLE; the result counts as consumed.
- If `flush` and `req_valid` arrive together in IDLE, `flush` wins and the request is not accepted.
- All arithmetic is unsigned on `eff`/`remaining`, which are 6 bits (0..32).

## Configuration
- `SHIFT_SEQ_RRX_EN` defined:
  - Applies only when `req_rrx` = 1 and `req_type` = 11 at accept.
  - The block performs one RUN cycle: `res_data` = {`req_carry`, Rm[31:1]}, `res_carry` = Rm[0].
  - `res_valid` rises 2 edges after accept.
- `SHIFT_SEQ_RRX_EN` undefined: `req_rrx` is ignored and the RRX path is not synthesized.

## Test plan
- LSL, Rm=0x8000_0001, amount=1, C=0 → `res_data` 0x0000_0002, `res_carry` 1; `res_valid` 2 edges after accept.
- LSR, Rm=0x8000_0000, amount=32 → `res_data` 0x0000_0000, `res_carry` 1, 2 RUN cycles, `res_valid` 3 edges after accept. Repeat with LSL, Rm=0xFFFF_FFFF, amount=40 → `res_data` 0, `res_carry` 0.
- ASR, Rm=0x8000_0000, amount=200 → `res_data` 0xFFFF_FFFF, `res_carry` 1.
- ROR, Rm=0x0000_0001, amount=33 → `res_data` 0x8000_0000, `res_carry` 1. ROR, Rm=0x8000_0001, amount=64 → `res_data` 0x8000_0001, `res_carry` 1, with `res_valid` 1 edge after accept.
- Any type, amount=0, C=1 → `res_data` = Rm, `res_carry` 1. Then hold `res_ready` low 3 cycles → outputs stable, `req_ready` 0, `busy` 1.
- Assert `rst` mid-RUN (LSL by 32) → outputs take reset values immediately. Separately, `flush` in RUN → IDLE next edge, `res_valid` never asserts. With `SHIFT_SEQ_RRX_EN`: RRX, Rm=0x3, C=1 → `res_data` 0x8000_0001, `res_carry` 1.
